// File: rtl/pc_next_unit.sv
// Next-PC selection for a single-issue fetch stage: sequential, branch, jal and jalr
// redirects, with a trap to TRAP_VEC on a misaligned redirect target.
module pc_next_unit #(
  parameter int unsigned       ADDR_W   = 8,
  parameter int unsigned       IMM_W    = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] TRAP_VEC = ADDR_W'(8'hF0)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch,
  input  logic              branch_ne,
  input  logic              zero_flag,
  input  logic              jal,
  input  logic              jalr,
  input  logic [IMM_W-1:0]  rs1_val,
  input  logic [IMM_W-1:0]  immgen,
  input  logic              trap_ack,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] link_addr,
  output logic              taken,
  output logic              trap
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              taken_q, taken_d;

  logic [ADDR_W-1:0] seq, br_tgt, jalr_sum, jalr_tgt, tgt;
  logic              cond, redirect;

  // Targets wrap modulo 2^ADDR_W, so operand bits above ADDR_W never matter.
  logic unused_hi;
  assign unused_hi = ^{rs1_val[IMM_W-1:ADDR_W], immgen[IMM_W-1:ADDR_W]};

  assign seq       = pc_q + ADDR_W'(4);
  assign br_tgt    = pc_q + {immgen[ADDR_W-2:0], 1'b0};
  assign jalr_sum  = rs1_val[ADDR_W-1:0] + immgen[ADDR_W-1:0];
  assign jalr_tgt  = {jalr_sum[ADDR_W-1:1], 1'b0};
  assign cond      = branch & (zero_flag ^ branch_ne);
  assign link_addr = seq;

  always_comb begin
    tgt      = seq;
    redirect = 1'b0;
    if (jalr) begin
      tgt      = jalr_tgt;
      redirect = 1'b1;
    end else if (jal || cond) begin
      tgt      = br_tgt;
      redirect = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    taken_d = taken_q;
    if (!stall) begin
      unique case (state_q)
        ST_RUN: begin
          taken_d = 1'b0;
          if (redirect && tgt[1]) begin
            pc_d    = TRAP_VEC;
            state_d = ST_TRAP;
          end else begin
            pc_d    = tgt;
            taken_d = redirect;
          end
        end
        ST_TRAP: begin
          // pc stays parked on the vector for the ack cycle; fetch resumes after.
          pc_d    = TRAP_VEC;
          taken_d = 1'b0;
          if (trap_ack) state_d = ST_RUN;
        end
        default: begin
          state_d = ST_RUN;
          pc_d    = RESET_PC;
          taken_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      taken_q <= taken_d;
    end
  end

  assign pc    = pc_q;
  assign taken = taken_q;
  assign trap  = (state_q == ST_TRAP);

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed vector bench for pc_next_unit at default parameters (ADDR_W=8, TRAP_VEC=0xF0).
module tb_pc_next_unit;

  logic        clk = 1'b0;
  logic        reset, stall, branch, branch_ne, zero_flag, jal, jalr, trap_ack;
  logic [63:0] rs1_val, immgen;
  logic [7:0]  pc, link_addr;
  logic        taken, trap;

  int checks = 0;
  int errors = 0;

  pc_next_unit #(.ADDR_W(8), .IMM_W(64), .RESET_PC(8'h00), .TRAP_VEC(8'hF0)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch(branch), .branch_ne(branch_ne),
    .zero_flag(zero_flag), .jal(jal), .jalr(jalr), .rs1_val(rs1_val), .immgen(immgen),
    .trap_ack(trap_ack), .pc(pc), .link_addr(link_addr), .taken(taken), .trap(trap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, stl, br, bne, zf, jl, jr, ack;
    logic [63:0] rs1, imm;
    logic [7:0] exp_pc;
    logic       exp_taken, exp_trap;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, stl, br, bne, zf, jl, jr, ack,
                              input logic [63:0] rs1, imm,
                              input logic [7:0] epc, input logic etk, etr);
    vec_t v;
    v.rst = rst; v.stl = stl; v.br = br; v.bne = bne; v.zf = zf;
    v.jl = jl; v.jr = jr; v.ack = ack; v.rs1 = rs1; v.imm = imm;
    v.exp_pc = epc; v.exp_taken = etk; v.exp_trap = etr;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [7:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    @(negedge clk);
    reset = v.rst; stall = v.stl; branch = v.br; branch_ne = v.bne; zero_flag = v.zf;
    jal = v.jl; jalr = v.jr; trap_ack = v.ack; rs1_val = v.rs1; immgen = v.imm;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int idx, input vec_t v);
    logic [7:0] exp_link;
    exp_link = v.exp_pc + 8'd4;
    check({tag, "_pc"}, idx, pc, v.exp_pc);
    check({tag, "_taken"}, idx, {7'd0, taken}, {7'd0, v.exp_taken});
    check({tag, "_trap"}, idx, {7'd0, trap}, {7'd0, v.exp_trap});
    check({tag, "_link"}, idx, link_addr, exp_link);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branch = 1'b0; branch_ne = 1'b0; zero_flag = 1'b0;
    jal = 1'b0; jalr = 1'b0; trap_ack = 1'b0; rs1_val = '0; immgen = '0;

    //              rst stl br bne zf jal jr ack rs1                    imm        pc     tk tr
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 64'h0,                  64'd0,     8'd0,   0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 64'h0,                  64'd0,     8'd4,   0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 64'h0,                  64'd0,     8'd8,   0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 64'h0,                  64'd0,     8'd12,  0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, 64'h0,                  64'd6,     8'd24,  1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 64'h0,                  -64'd6,    8'd12,  1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 64'h0,                  64'd6,     8'd16,  0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 64'h0,                  64'd4,     8'd24,  1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0, 64'h0,                  64'd4,     8'd28,  0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 64'h0,                  64'd112,   8'd252, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 64'h0,                  64'd0,     8'd0,   0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 64'h0,                  64'd0,     8'd4,   0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 64'h0,                  -64'd4,    8'd252, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 64'h0,                  -64'd106,  8'd40,  1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 64'h0,                  64'd4,     8'd40,  1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 64'h0,                  64'd4,     8'd40,  1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 64'h0,                  64'd4,     8'd40,  1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 64'h0,                  64'd4,     8'd48,  1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1, 1, 1, 0, 64'h31,                 64'd3,     8'h34,  1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 64'h30,                 64'd6,     8'hF0,  0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 64'h0,                  64'd2,     8'hF0,  0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 64'h0,                  64'd0,     8'hF0,  0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 64'h0,                  64'd0,     8'hF0,  0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 64'h0,                  64'd0,     8'hF4,  0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 64'h0,                  64'd0,     8'hF8,  0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 64'h0,                  64'd1,     8'hF0,  0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 64'h0,                  64'd0,     8'd0,   0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 64'h0,                  64'd8,     8'd0,   0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 64'h0,                  64'd0,     8'd4,   0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 64'h0,                  64'd0,     8'd8,   0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 64'h20,                 64'h11,    8'h30,  1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 64'h1234_0000_0000_00FF, 64'd5,    8'h04,  1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, 64'h0,                  64'd1,     8'hF0,  0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 64'h0,                  64'd0,     8'hF0,  0, 1));

    foreach (vecs[i]) begin
      drive(vecs[i]);
      check_all("vec", i, vecs[i]);
    end

    // Reset held for several cycles while in TRAP, with stall/ack/jump noise on the inputs.
    for (int unsigned k = 0; k < 3; k++) begin
      drive(mk(1, k[0], 0, 0, 0, 1, 1, k[1], 64'h30, 64'd6, 8'd0, 0, 0));
      check_all("rst_hold", int'(k), mk(1, 0, 0, 0, 0, 0, 0, 0, 64'h0, 64'd0, 8'd0, 0, 0));
    end
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 64'h0, 64'd0, 8'd4, 0, 0));
    check_all("rst_rel", 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 64'h0, 64'd0, 8'd4, 0, 0));
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 64'h0, 64'd0, 8'd8, 0, 0));
    check_all("rst_rel", 1, mk(0, 0, 0, 0, 0, 0, 0, 0, 64'h0, 64'd0, 8'd8, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_next_unit.md
PC_NEXT_UNIT -- requirements
Module: pc_next_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, PC/address width in bits.
REQ-002 SHALL have parameter IMM_W, default 64, immediate and register-operand width.
REQ-003 SHALL have parameter RESET_PC, default 0, PC value loaded on reset.
REQ-004 SHALL have parameter TRAP_VEC, default 8'hF0 (ADDR_W bits), PC value loaded on a misaligned-target trap.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port stall  input  1  hold PC and state this cycle.
REQ-008 SHALL have port branch  input  1  conditional branch instruction in execute.
REQ-009 SHALL have port branch_ne  input  1  branch sense: 0 = taken on zero_flag=1 (BEQ), 1 = taken on zero_flag=0 (BNE).
REQ-010 SHALL have port zero_flag  input  1  ALU zero result.
REQ-011 SHALL have port jal  input  1  unconditional PC-relative jump.
REQ-012 SHALL have port jalr  input  1  register-indirect jump.
REQ-013 SHALL have port rs1_val  input  IMM_W  base register value for jalr.
REQ-014 SHALL have port immgen  input  IMM_W  sign-extended immediate.
REQ-015 SHALL have port trap_ack  input  1  single-cycle pulse releasing the TRAP state.
REQ-016 SHALL have port pc  output  ADDR_W  registered current PC.
REQ-017 SHALL have port link_addr  output  ADDR_W  combinational pc+4, the return address for jal/jalr.
REQ-018 SHALL have port taken  output  1  registered; 1 for one cycle after a redirect was applied.
REQ-019 SHALL have port trap  output  1  registered; 1 while in TRAP state.

Function
REQ-020 SHALL implement a two-state FSM: RUN and TRAP.
REQ-021 SHALL compute seq = pc + 4, br_tgt = pc + (immgen<<1), jalr_tgt = (rs1_val + immgen) with bit 0 cleared; all truncated modulo 2^ADDR_W (wrap-around, no overflow flag).
REQ-022 SHALL evaluate cond = branch & (zero_flag XOR branch_ne).
REQ-023 SHALL select the target in RUN with priority jalr > jal > cond > sequential; jal and cond both use br_tgt.
REQ-024 SHALL treat a selected non-sequential target with bit 1 set as misaligned: pc <= TRAP_VEC, state <= TRAP, taken <= 0.
REQ-025 SHALL, in RUN with an aligned redirect, load pc with the target and set taken=1 on the next cycle; otherwise taken=0.
REQ-026 SHALL, while stall=1, hold pc, state and taken unchanged; stall overrides every control input except reset.
REQ-027 SHALL, in TRAP, hold pc at TRAP_VEC and ignore branch/jal/jalr.
REQ-028 SHALL, on trap_ack=1 in TRAP (stall=0), return to RUN with pc held at TRAP_VEC that cycle; sequential fetch resumes next cycle.
REQ-029 SHALL ignore trap_ack in RUN.
REQ-030 SHALL update pc with one-cycle latency: a control input sampled at edge N is reflected in pc after edge N.

Reset
REQ-031 SHALL, when reset=1 at a clock edge, set pc=RESET_PC, state=RUN, taken=0, trap=0, regardless of stall, trap or any other input.
REQ-032 SHALL hold the reset values for every cycle reset stays high, including reset asserted mid-TRAP.

Verification
REQ-033 SHALL verify reset then 3 idle cycles (ADDR_W=8): pc 0 -> 4 -> 8 -> 12, taken=0.
REQ-034 SHALL verify pc=12, branch=1, branch_ne=0, zero_flag=1, immgen=6: pc=24, taken=1; with zero_flag=0: pc=16, taken=0.
REQ-035 SHALL verify wrap: pc=252 sequential -> pc=0; pc=4, jal, immgen=-4 -> pc=252.
REQ-036 SHALL verify stall=1 for 3 cycles with jal asserted at pc=40: pc stays 40; after release with jal still high, pc=40+2*imm.
REQ-037 SHALL verify jalr rs1_val=0x31, immgen=3 -> pc=0x34; rs1_val=0x30, immgen=6 -> pc=0xF0, trap=1; trap_ack -> trap=0, pc 0xF0 then 0xF4.
REQ-038 SHALL verify reset asserted during TRAP: next pc=0, trap=0, sequential fetch afterwards.
